dual_port_ram_arbiter: RTL and testbench
========================================

// Module: dual_port_ram_arbiter
// PURPOSE
//  Shares one 8-deep single-port RAM array between two requesters, port A and port B.
//  Each port uses a req/gnt handshake. The block arbitrates round-robin, then sequences
//  the single access per grant. Sits between two masters and the memory element.
//  Write collisions are serialized, never lost.
// PARAMETERS
//  DATA_W  8  data width of the RAM and of the rdata/wdata buses
//  ADDR_W  3  address width; DEPTH = 2**ADDR_W words
// PORTS
//  clk_i      in   1       single clock; all logic on the rising edge
//  rst_i      in   1       synchronous, active-high reset
//  req_ia     in   1       port A request; held high until gnt_oa is sampled
//  we_ia      in   1       port A write enable (1 = write, 0 = read); stable while req_ia=1
//  addr_ia    in   ADDR_W  port A address; stable while req_ia=1
//  data_ina   in   DATA_W  port A write data; stable while req_ia=1
//  gnt_oa     out  1       port A grant, one-cycle pulse
//  rvalid_oa  out  1       port A read data valid, one-cycle pulse
//  data_outa  out  DATA_W  port A read data; holds its value until the next A read
//  req_ib, we_ib, addr_ib, data_inb, gnt_ob, rvalid_ob, data_outb: port B mirror
//  busy_o     out  1       1 while the FSM is in ACCESS
// BEHAVIOUR
//  Reset (rst_i=1 at an edge):
//   - gnt_o*, rvalid_o* and busy_o go to 0; data_out* go to 0.
//   - FSM goes to IDLE; last_gnt goes to B, so A wins the first tie.
//   - RAM contents are not reset.
//  FSM states: IDLE, ACCESS.
//  IDLE, at an edge:
//   - Neither req: stay in IDLE.
//   - Exactly one req: that port wins.
//   - Both req: the port != last_gnt wins.
//   - On a win: capture we/addr/wdata, set gnt_o<winner>=1 for one cycle,
//     set last_gnt=winner, go to ACCESS.
//  ACCESS, at an edge:
//   - Write: RAM[addr] <= wdata.
//   - Read: data_out<winner> <= RAM[addr], rvalid_o<winner>=1 for one cycle.
//   - go to IDLE.
//   - req inputs are NOT sampled in ACCESS.
//  Handshake:
//   - A requester that samples gnt=1 at an edge may drop req or present a new command
//     at that same edge.
//   - The new command is arbitrated at the following edge.
//  Latency, with the req sampled at edge k:
//   - gnt is high for cycle k..k+1.
//   - The RAM write, or the read data capture, happens at edge k+1.
//   - rvalid/data_out are valid for cycle k+1..k+2.
//   - Peak throughput: one access per 2 cycles. With continuous reqs on both ports,
//     each port gets one access per 4 cycles.
//  Simultaneous same-address access: the winner completes first. A read granted before
//  a write returns the old data. A read granted after returns the new data.
//  Write-write to the same address: the last granted write persists.
//  Reset mid-operation: if rst_i=1 at the ACCESS edge, the write is suppressed and no
//  rvalid is produced. The command is dropped, not retried.
//  Invariants:
//   - gnt_oa and gnt_ob are never both 1.
//   - rvalid_o* is never 1 for a write.
//   - busy_o==1 exactly in the cycle gnt is high.
// CONFIGURATION
//  MEM_ARB_FIXED_PRIO_EN
//   - Defined: fixed priority. Port A always wins a tie and last_gnt is ignored;
//     B is served only when req_ia=0 in IDLE.
//   - Undefined (default): round-robin as described above.
// TESTING
//  1. Reset, then A write addr 5 = 8'h0A.
//     -> gnt_oa pulses 1 cycle; rvalid_oa stays 0; gnt_ob stays 0.
//  2. A read addr 5.
//     -> rvalid_oa pulses one cycle after gnt_oa; data_outa = 8'h0A.
//  3. After reset, both ports write addr 3 in the same cycle: A 8'h11, B 8'h22.
//     -> gnt_oa, then gnt_ob 2 cycles later; a subsequent B read of addr 3 returns 8'h22.
//  4. Both ports hold continuous reads of addr 0/1 for 16 cycles.
//     -> grants alternate A,B,A,B; each gnt is 2 cycles after the previous one;
//        never both in one cycle.
//  5. Addr 2 = 8'h33 preloaded. Same cycle: A read addr 2, B write addr 2 = 8'hAB.
//     -> data_outa = 8'h33; a following A read returns 8'hAB.
//  6. Addr 6 = 8'h44. A write addr 6 = 8'h55, with rst_i=1 on the ACCESS edge.
//     -> all outputs 0; a later read of addr 6 returns 8'h44.
//     With MEM_ARB_FIXED_PRIO_EN: rerun 4 -> gnt_oa on every grant, gnt_ob never.

Source files
------------

// File: rtl/dual_port_ram_arbiter.sv
// dual_port_ram_arbiter: round-robin req/gnt arbiter sharing one single-port RAM between ports A and B.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (A always wins a tie).
module dual_port_ram_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_ia,
  input  logic              we_ia,
  input  logic [ADDR_W-1:0] addr_ia,
  input  logic [DATA_W-1:0] data_ina,
  output logic              gnt_oa,
  output logic              rvalid_oa,
  output logic [DATA_W-1:0] data_outa,
  input  logic              req_ib,
  input  logic              we_ib,
  input  logic [ADDR_W-1:0] addr_ib,
  input  logic [DATA_W-1:0] data_inb,
  output logic              gnt_ob,
  output logic              rvalid_ob,
  output logic [DATA_W-1:0] data_outb,
  output logic              busy_o
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state_q, state_d;
  logic last_b_q, last_b_d, win_b_q, win_b_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, data_a_q, data_a_d, data_b_q, data_b_d;
  logic gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d, rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
  logic mem_we, pick_b;
  logic [DATA_W-1:0] mem [DEPTH];
`ifdef MEM_ARB_FIXED_PRIO_EN
  assign pick_b = req_ib & ~req_ia;
`else
  assign pick_b = req_ib & (~req_ia | ~last_b_q);
`endif
  always_comb begin
    state_d = state_q;
    last_b_d = last_b_q;
    win_b_d = win_b_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    gnt_a_d = 1'b0;
    gnt_b_d = 1'b0;
    rvalid_a_d = 1'b0;
    rvalid_b_d = 1'b0;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    mem_we = 1'b0;
    if (state_q == IDLE) begin
      if (req_ia | req_ib) begin
        state_d = ACCESS;
        win_b_d = pick_b;
        last_b_d = pick_b;
        we_d = pick_b ? we_ib : we_ia;
        addr_d = pick_b ? addr_ib : addr_ia;
        wdata_d = pick_b ? data_inb : data_ina;
        gnt_a_d = ~pick_b;
        gnt_b_d = pick_b;
      end
    end else begin
      state_d = IDLE;
      mem_we = we_q;
      rvalid_a_d = ~we_q & ~win_b_q;
      rvalid_b_d = ~we_q & win_b_q;
      data_a_d = rvalid_a_d ? mem[addr_q] : data_a_q;
      data_b_d = rvalid_b_d ? mem[addr_q] : data_b_q;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_b_q <= 1'b1;
      win_b_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      state_q <= state_d;
      last_b_q <= last_b_d;
      win_b_q <= win_b_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end
  // RAM is never reset; a reset on the ACCESS edge suppresses the write
  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_we) mem[addr_q] <= wdata_q;
  end
  assign gnt_oa = gnt_a_q;
  assign gnt_ob = gnt_b_q;
  assign rvalid_oa = rvalid_a_q;
  assign rvalid_ob = rvalid_b_q;
  assign data_outa = data_a_q;
  assign data_outb = data_b_q;
  assign busy_o = state_q == ACCESS;
endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
// tb_dual_port_ram_arbiter: directed bench with a transaction-level model checked every cycle.
module tb_dual_port_ram_arbiter;
  logic clk = 1'b0, rst_i = 1'b1;
  logic req_ia = 1'b0, we_ia = 1'b0, req_ib = 1'b0, we_ib = 1'b0;
  logic [2:0] addr_ia = '0, addr_ib = '0;
  logic [7:0] data_ina = '0, data_inb = '0;
  logic gnt_oa, rvalid_oa, gnt_ob, rvalid_ob, busy_o;
  logic [7:0] data_outa, data_outb;
  int vectors = 0, errors = 0;
  dual_port_ram_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_ia(req_ia), .we_ia(we_ia), .addr_ia(addr_ia), .data_ina(data_ina),
    .gnt_oa(gnt_oa), .rvalid_oa(rvalid_oa), .data_outa(data_outa),
    .req_ib(req_ib), .we_ib(we_ib), .addr_ib(addr_ib), .data_inb(data_inb),
    .gnt_ob(gnt_ob), .rvalid_ob(rvalid_ob), .data_outb(data_outb),
    .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  typedef struct {bit b; bit we; logic [2:0] addr; logic [7:0] data;} cmd_t;
  cmd_t inflight[$];
  logic [7:0] m_mem [8];
  bit m_last_b = 1'b1, chk_en = 1'b0, rec_en = 1'b0;
  logic e_ga = 0, e_gb = 0, e_ra = 0, e_rb = 0, e_busy = 0;
  logic [7:0] e_da = '0, e_db = '0;
  int cyc = 0;
  int g_cyc[$];
  bit g_b[$];
  // A granted command occupies the RAM for the following cycle; no request is looked at then
  always @(posedge clk) begin
    e_ga = 0; e_gb = 0; e_ra = 0; e_rb = 0; e_busy = 0;
    if (rst_i) begin
      inflight.delete();
      m_last_b = 1'b1;
      e_da = '0; e_db = '0;
    end else if (inflight.size() != 0) begin
      cmd_t c;
      c = inflight.pop_front();
      if (c.we) m_mem[c.addr] = c.data;
      else if (c.b) begin e_rb = 1; e_db = m_mem[c.addr]; end
      else begin e_ra = 1; e_da = m_mem[c.addr]; end
    end else if (req_ia || req_ib) begin
      cmd_t c;
`ifdef MEM_ARB_FIXED_PRIO_EN
      c.b = !req_ia;
`else
      c.b = req_ia && req_ib ? !m_last_b : req_ib;
`endif
      c.we = c.b ? we_ib : we_ia;
      c.addr = c.b ? addr_ib : addr_ia;
      c.data = c.b ? data_inb : data_ina;
      inflight.push_back(c);
      m_last_b = c.b;
      e_ga = !c.b; e_gb = c.b; e_busy = 1;
    end
  end
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      check("gnt_oa", {7'b0, gnt_oa}, {7'b0, e_ga});
      check("gnt_ob", {7'b0, gnt_ob}, {7'b0, e_gb});
      check("rvalid_oa", {7'b0, rvalid_oa}, {7'b0, e_ra});
      check("rvalid_ob", {7'b0, rvalid_ob}, {7'b0, e_rb});
      check("busy_o", {7'b0, busy_o}, {7'b0, e_busy});
      check("data_outa", data_outa, e_da);
      check("data_outb", data_outb, e_db);
      check("gnt_exclusive", {7'b0, gnt_oa & gnt_ob}, 8'h00);
    end
    if (rec_en && (gnt_oa || gnt_ob)) begin
      g_cyc.push_back(cyc);
      g_b.push_back(gnt_ob);
    end
  end
  task automatic do_reset();
    rst_i = 1;
    repeat (2) @(negedge clk);
    rst_i = 0;
  endtask
  task automatic run(input logic ra, input logic wa, input logic [2:0] aa, input logic [7:0] da,
                     input logic rb, input logic wb, input logic [2:0] ab, input logic [7:0] db);
    req_ia = ra; we_ia = wa; addr_ia = aa; data_ina = da;
    req_ib = rb; we_ib = wb; addr_ib = ab; data_inb = db;
    for (int i = 0; i < 20 && (req_ia || req_ib); i++) begin
      @(negedge clk);
      if (gnt_oa) req_ia = 0;
      if (gnt_ob) req_ib = 0;
    end
    vectors++;
    if (req_ia || req_ib) begin
      errors++;
      $display("FAIL run_timeout: req still pending a=%b b=%b, required both granted", req_ia, req_ib);
      req_ia = 0; req_ib = 0;
    end
    repeat (2) @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst_i = 0;
    chk_en = 1;
    // 1: A write, only gnt_oa pulses
    rec_en = 1;
    run(1, 1, 3'd5, 8'h0A, 0, 0, 3'd0, 8'h00);
    rec_en = 0;
    check("t1_grants", 8'(g_b.size()), 8'd1);
    if (g_b.size() > 0) check("t1_port", {7'b0, g_b[0]}, 8'h00);
    // 2: A read back
    run(1, 0, 3'd5, 8'h00, 0, 0, 3'd0, 8'h00);
    check("t2_rdata", data_outa, 8'h0A);
    // 3: simultaneous writes to addr 3, B read sees the later one
    do_reset();
    g_cyc.delete(); g_b.delete(); rec_en = 1;
    run(1, 1, 3'd3, 8'h11, 1, 1, 3'd3, 8'h22);
    rec_en = 0;
    check("t3_grants", 8'(g_b.size()), 8'd2);
    if (g_b.size() == 2) begin
      check("t3_first", {7'b0, g_b[0]}, 8'h00);
      check("t3_gap", 8'(g_cyc[1] - g_cyc[0]), 8'd2);
    end
    run(0, 0, 3'd0, 8'h00, 1, 0, 3'd3, 8'h00);
    check("t3_rdata", data_outb, 8'h22);
    // 4: continuous reads on both ports
    run(1, 1, 3'd0, 8'hC0, 0, 0, 3'd0, 8'h00);
    run(0, 0, 3'd0, 8'h00, 1, 1, 3'd1, 8'hC1);
    do_reset();
    g_cyc.delete(); g_b.delete();
    req_ia = 1; we_ia = 0; addr_ia = 3'd0;
    req_ib = 1; we_ib = 0; addr_ib = 3'd1;
    rec_en = 1;
    repeat (16) @(negedge clk);
    req_ia = 0; req_ib = 0;
    repeat (3) @(negedge clk);
    rec_en = 0;
    check("t4_grants", 8'(g_b.size()), 8'd8);
    for (int i = 0; i < g_b.size(); i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      check("t4_port", {7'b0, g_b[i]}, 8'h00);
`else
      check("t4_port", {7'b0, g_b[i]}, 8'(i % 2));
`endif
      if (i > 0) check("t4_gap", 8'(g_cyc[i] - g_cyc[i-1]), 8'd2);
    end
    check("t4_douta", data_outa, 8'hC0);
    // 5: A read races B write on addr 2
    do_reset();
    run(0, 0, 3'd0, 8'h00, 1, 1, 3'd2, 8'h33);
    run(1, 0, 3'd2, 8'h00, 1, 1, 3'd2, 8'hAB);
    check("t5_old", data_outa, 8'h33);
    run(1, 0, 3'd2, 8'h00, 0, 0, 3'd0, 8'h00);
    check("t5_new", data_outa, 8'hAB);
    // 6: reset on the ACCESS edge drops the write
    run(1, 1, 3'd6, 8'h44, 0, 0, 3'd0, 8'h00);
    req_ia = 1; we_ia = 1; addr_ia = 3'd6; data_ina = 8'h55;
    for (int i = 0; i < 10 && !gnt_oa; i++) @(negedge clk);
    check("t6_gnt", {7'b0, gnt_oa}, 8'h01);
    rst_i = 1; req_ia = 0;
    @(negedge clk);
    rst_i = 0;
    check("t6_douta", data_outa, 8'h00);
    check("t6_busy", {7'b0, busy_o}, 8'h00);
    repeat (2) @(negedge clk);
    run(1, 0, 3'd6, 8'h00, 0, 0, 3'd0, 8'h00);
    check("t6_rdata", data_outa, 8'h44);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
